// File: rtl/ha_accum_pkg.sv
// Shared constants and types for the HA-array row accumulator.
package ha_accum_pkg;

    localparam int NUM_ARRAYS = 4;
    localparam int B_W        = 7;
    localparam int T_W        = 9;
    localparam int P_W        = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [1:0] row_idx_t;

endpackage

// File: rtl/ha_row_weigher.sv
// Combinational row weigher: term = (t + (b << 2)) << (2 * idx), truncated to P_W bits.
module ha_row_weigher
    import ha_accum_pkg::*;
(
    input  logic [B_W-1:0] b_i,
    input  logic [T_W-1:0] t_i,
    input  row_idx_t       idx_i,
    output logic [P_W-1:0] term_o
);

    logic [P_W-1:0] row_sum;

    // Row value never exceeds 1019, so a P_W-bit sum is exact; the shift then truncates.
    assign row_sum = {{(P_W-T_W){1'b0}}, t_i} + {{(P_W-B_W-2){1'b0}}, b_i, 2'b00};
    assign term_o  = row_sum << {idx_i, 1'b0};

endmodule

// File: rtl/ha_array_accum.sv
// Sequential reducer of four HA-array rows into a 16-bit product, one row per cycle.
// Optional macro HA_ACC_PERF_EN adds a saturating done_count output.
module ha_array_accum
    import ha_accum_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B_W-1:0] ha_array_0_b,
    input  logic [B_W-1:0] ha_array_1_b,
    input  logic [B_W-1:0] ha_array_2_b,
    input  logic [B_W-1:0] ha_array_3_b,
    input  logic [T_W-1:0] ha_array_0_t,
    input  logic [T_W-1:0] ha_array_1_t,
    input  logic [T_W-1:0] ha_array_2_t,
    input  logic [T_W-1:0] ha_array_3_t,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] product
`ifdef HA_ACC_PERF_EN
    ,
    output logic [P_W-1:0] done_count
`endif
);

    logic [B_W-1:0] b_in [NUM_ARRAYS];
    logic [T_W-1:0] t_in [NUM_ARRAYS];
    logic [B_W-1:0] b_q  [NUM_ARRAYS];
    logic [T_W-1:0] t_q  [NUM_ARRAYS];

    state_t         state_q, state_d;
    row_idx_t       idx_q, idx_d;
    logic [P_W-1:0] acc_q, acc_d;
    logic [P_W-1:0] product_q, product_d;
    logic [P_W-1:0] term;
    logic           capture_en;

    assign b_in[0] = ha_array_0_b;
    assign b_in[1] = ha_array_1_b;
    assign b_in[2] = ha_array_2_b;
    assign b_in[3] = ha_array_3_b;
    assign t_in[0] = ha_array_0_t;
    assign t_in[1] = ha_array_1_t;
    assign t_in[2] = ha_array_2_t;
    assign t_in[3] = ha_array_3_t;

    // Row vectors are sampled only at the acceptance edge.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ARRAYS; gi++) begin : g_capture
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q[gi] <= '0;
                    t_q[gi] <= '0;
                end else if (capture_en) begin
                    b_q[gi] <= b_in[gi];
                    t_q[gi] <= t_in[gi];
                end
            end
        end
    endgenerate

    ha_row_weigher u_weigher (
        .b_i    (b_q[idx_q]),
        .t_i    (t_q[idx_q]),
        .idx_i  (idx_q),
        .term_o (term)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        product_d  = product_q;
        capture_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    capture_en = 1'b1;
                    acc_d      = '0;
                    idx_d      = '0;
                    state_d    = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + term;
                idx_d = idx_q + row_idx_t'(1);
                if (idx_q == row_idx_t'(NUM_ARRAYS - 1)) begin
                    product_d = acc_q + term;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

`ifdef HA_ACC_PERF_EN
    logic [P_W-1:0] done_count_q, done_count_d;

    always_comb begin
        done_count_d = done_count_q;
        if (out_valid && out_ready && (done_count_q != {P_W{1'b1}})) begin
            done_count_d = done_count_q + P_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_count_q <= '0;
        end else begin
            done_count_q <= done_count_d;
        end
    end

    assign done_count = done_count_q;
`endif

endmodule

// File: tb/tb_ha_array_accum.sv
// Self-checking bench for ha_array_accum: behavioural model, per-cycle compare, directed literals.
module tb_ha_array_accum;
    import ha_accum_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [15:0]    product;
    logic [8:0]     t_v [4];
    logic [6:0]     b_v [4];
`ifdef HA_ACC_PERF_EN
    logic [15:0]    done_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ha_array_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ha_array_0_b (b_v[0]),
        .ha_array_1_b (b_v[1]),
        .ha_array_2_b (b_v[2]),
        .ha_array_3_b (b_v[3]),
        .ha_array_0_t (t_v[0]),
        .ha_array_1_t (t_v[1]),
        .ha_array_2_t (t_v[2]),
        .ha_array_3_t (t_v[3]),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product)
`ifdef HA_ACC_PERF_EN
        ,
        .done_count   (done_count)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Weighted sum of all rows, wrapped to 16 bits.
    function automatic logic [15:0] golden();
        int sum = 0;
        for (int k = 0; k < 4; k++) begin
            sum += (int'(t_v[k]) + 4 * int'(b_v[k])) * (1 << (2 * k));
        end
        return 16'(sum % 65536);
    endfunction

    task automatic clear_rows();
        for (int k = 0; k < 4; k++) begin
            t_v[k] = '0;
            b_v[k] = '0;
        end
    endtask

    task automatic random_rows();
        for (int k = 0; k < 4; k++) begin
            t_v[k] = 9'($urandom);
            b_v[k] = 7'($urandom);
        end
    endtask

    // Upstream HA-array model: row k adds the partial products of y bits 2k and 2k+1.
    task automatic upstream_rows(input logic [7:0] x, input logic [7:0] y);
        logic [8:0] p0, p1, c;
        for (int k = 0; k < 4; k++) begin
            p0 = {1'b0, x & {8{y[2*k]}}};
            p1 = {x & {8{y[2*k+1]}}, 1'b0};
            c  = p0 & p1;
            t_v[k] = p0 ^ p1;
            b_v[k] = c[7:1];
        end
    endtask

    // Behavioural model: busy from acceptance until the output handshake.
    logic        m_busy;
    int          m_cnt;
    logic [15:0] m_exp;
    logic [15:0] m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_exp  <= '0;
            m_done <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_exp  <= golden();
            end
        end else if (m_cnt < 4) begin
            m_cnt <= m_cnt + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
            if (m_done != 16'hFFFF) m_done <= m_done + 16'd1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", int'(in_ready), int'(!m_busy));
            chk("out_valid", int'(out_valid), int'(m_busy && m_cnt == 4));
            if (m_busy && m_cnt == 4) chk("product", int'(product), int'(m_exp));
`ifdef HA_ACC_PERF_EN
            chk("done_count", int'(done_count), int'(m_done));
`endif
        end
    end

    // One transaction: rows already on t_v/b_v; returns the observed product and latency.
    task automatic do_txn(input int hold, output logic [15:0] got, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        random_rows();
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        got = product;
        repeat (hold) @(posedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic directed(input string name, input int hold, input int exp);
        logic [15:0] got;
        int lat;
        do_txn(hold, got, lat);
        chk({name, "_product"}, int'(got), exp);
        chk({name, "_latency"}, lat, 4);
    endtask

    initial begin
        logic [15:0] got;
        int lat;
        logic [7:0] x, y;

        clear_rows();
        #12;
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_product", int'(product), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        clear_rows(); t_v[0] = 9'h1FF; directed("t0_max", 0, 511);
        clear_rows(); b_v[1] = 7'h01;  directed("b1_lsb", 0, 16);
        clear_rows(); t_v[3] = 9'h001; directed("t3_lsb", 0, 64);
        clear_rows(); b_v[2] = 7'h40;  directed("b2_msb", 0, 4096);
        for (int k = 0; k < 4; k++) begin
            t_v[k] = 9'h1FF;
            b_v[k] = 7'h7F;
        end
        directed("all_max_wrap", 0, 21079);
        upstream_rows(8'hFF, 8'hFF);
        directed("ff_x_ff_hold", 10, 65025);

        // Reset while the third row is being added.
        clear_rows(); t_v[0] = 9'h0AA;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_product", int'(product), 0);
        chk("midreset_in_ready", int'(in_ready), 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        upstream_rows(8'hA5, 8'h3C);
        directed("after_reset", 0, 9900);

        for (int i = 0; i < 30; i++) begin
            random_rows();
            do_txn(int'($urandom_range(0, 3)), got, lat);
            chk("rand_latency", lat, 4);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            upstream_rows(x, y);
            do_txn(0, got, lat);
            chk("mult_product", int'(got), int'(x) * int'(y));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
